// File: rtl/rle_pkg.sv
// Shared types and helpers for the run-length decompressor.
package rle_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDone
  } rle_state_e;

  // Smaller of two unsigned values; used to clip a run to the room left in a word.
  function automatic int unsigned min_len(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/rle_decompressor_bit_packer.sv
// Word assembly register with an MSB-first k-bit insert. The inserted (or zero-padded)
// word is presented combinationally so the top can move it straight to the output
// register on the same edge it completes.
module bit_packer
  import rle_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned BW     = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic              bit_val,
  input  logic [BW-1:0]     k,
  input  logic [BW-1:0]     bit_idx,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] top_k;
  logic [WORD_W-1:0] mask;

  // Mask covers bits WORD_W-1-bit_idx down to WORD_W-bit_idx-k.
  always_comb begin
    top_k = ~({WORD_W{1'b1}} >> k);
    mask  = top_k >> bit_idx;
    word  = (asm_q & ~mask) | (bit_val ? mask : '0);
  end

  // Assembly register: cleared on frame start or word hand-off, else accumulates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q <= '0;
    end else if (clear) begin
      asm_q <= '0;
    end else if (en) begin
      asm_q <= word;
    end
  end

endmodule

// File: rtl/rle_decompressor.sv
// Run-length decompressor: expands {bit, run} tokens into MSB-first packed words with
// valid/ready on both sides, word/bit position tracking and an end-of-frame done flag.
module rle_decompressor
  import rle_pkg::*;
#(
  parameter int unsigned WORD_W      = 8,
  parameter int unsigned RUN_W       = 2,
  parameter int unsigned IDX_W       = 32,
  parameter int unsigned TOTAL_WORDS = 1024,
  localparam int unsigned BW         = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              work,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bit,
  input  logic [RUN_W-1:0]  in_run,
  input  logic              in_last,
  output logic [WORD_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  byteIndx,
  output logic [BW-1:0]     bitIndx,
  output logic              done
);

  // Wide compare so a TOTAL_WORDS beyond the index range simply never terminates.
  localparam int unsigned CW = (IDX_W > 32) ? IDX_W + 1 : 33;
  localparam logic [BW-1:0] FullIdx = BW'(WORD_W);

  rle_state_e        st_q;
  logic [BW-1:0]     bit_idx_q;
  logic [IDX_W-1:0]  byte_idx_q;
  logic [RUN_W-1:0]  run_left_q;
  logic              bit_val_q;
  logic              last_q;
  logic [WORD_W-1:0] out_q;
  logic              out_valid_q;

  logic              full, out_free, expanding, in_flush, xfer, last_hit, pk_val;
  logic [BW-1:0]     room, k_run, pk_k, new_idx;
  logic [WORD_W-1:0] word;

  // Expansion amount, packer controls and the word hand-off condition.
  always_comb begin
    full      = (bit_idx_q == FullIdx);
    out_free  = !out_valid_q || out_ready;
    room      = FullIdx - bit_idx_q;
    k_run     = BW'(min_len(32'(run_left_q), 32'(room)));
    expanding = (st_q == StRun) && (run_left_q != '0) && !full;
    in_flush  = (st_q == StFlush);
    pk_val    = in_flush ? 1'b0 : bit_val_q;
    pk_k      = expanding ? k_run : (in_flush ? room : '0);
    new_idx   = bit_idx_q + pk_k;
    xfer      = !work && ((st_q == StRun) || in_flush) && (new_idx == FullIdx) && out_free;
    last_hit  = (CW'(byte_idx_q) + CW'(1)) == CW'(TOTAL_WORDS);
  end

  assign in_ready  = (st_q == StRun) && (run_left_q == '0) && !full && !last_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign byteIndx  = byte_idx_q;
  assign bitIndx   = bit_idx_q;
  assign done      = (st_q == StDone);

  bit_packer #(
    .WORD_W (WORD_W),
    .BW     (BW)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .clear   (work || xfer),
    .en      (expanding),
    .bit_val (pk_val),
    .k       (pk_k),
    .bit_idx (bit_idx_q),
    .word    (word)
  );

  // Control FSM, token capture, run expansion and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= StIdle;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      run_left_q  <= '0;
      bit_val_q   <= 1'b0;
      last_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (work) begin
        st_q       <= StRun;
        bit_idx_q  <= '0;
        byte_idx_q <= '0;
        run_left_q <= '0;
        last_q     <= 1'b0;
      end else begin
        unique case (st_q)
          StRun: begin
            if (in_valid && in_ready) begin
              run_left_q <= in_run;
              bit_val_q  <= in_bit;
              last_q     <= in_last;
            end else if (expanding) begin
              run_left_q <= run_left_q - RUN_W'(pk_k);
              bit_idx_q  <= new_idx;
            end else if (last_q && !full && (run_left_q == '0)) begin
              // Last run fully expanded: pad a partial word, else finish once out drains.
              if (bit_idx_q != '0) begin
                st_q <= StFlush;
              end else if (out_free) begin
                st_q <= StDone;
              end
            end
          end
          default: ;
        endcase
        if (xfer) begin
          out_q       <= word;
          out_valid_q <= 1'b1;
          bit_idx_q   <= '0;
          byte_idx_q  <= byte_idx_q + IDX_W'(1);
          if (last_hit || in_flush) begin
            st_q       <= StDone;
            run_left_q <= '0;
            last_q     <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rle_decompressor.sv
// Self-checking bench: directed vector table, hand-written multi-cycle sequences and
// randomised frames checked against a bit-queue reference model.
module tb_rle_decompressor;

  localparam int unsigned WW = 8;
  localparam int unsigned RW = 4;
  localparam int unsigned IW = 8;
  localparam int unsigned TW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          work = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_bit = 1'b0;
  logic [RW-1:0] in_run = '0;
  logic          in_last = 1'b0;
  logic [WW-1:0] out;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] byteIndx;
  logic [3:0]    bitIndx;
  logic          done;

  logic rnd_mode = 1'b0;
  logic rnd_rdy = 1'b0;
  logic rdy_fix = 1'b1;
  assign out_ready = rnd_mode ? rnd_rdy : rdy_fix;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  logic [7:0] got[$];
  int got_cyc[$];

  typedef struct {
    int         n;
    bit         b[3];
    int         r[3];
    bit         last;
    int         nexp;
    logic [7:0] w[2];
    int         ebyte;
    int         ebit;
    bit         edone;
  } vec_t;
  vec_t vecs[7];

  // Random-frame model state.
  bit   q[$];
  int   cum, ntok, nw, rr, acc0;
  bit   lastf, bb, ll, exp_done;
  logic [7:0] ew;

  rle_decompressor #(
    .WORD_W      (WW),
    .RUN_W       (RW),
    .IDX_W       (IW),
    .TOTAL_WORDS (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .work      (work),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_run    (in_run),
    .in_last   (in_last),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .byteIndx  (byteIndx),
    .bitIndx   (bitIndx),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1 rnd_rdy = 1'($urandom_range(0, 1));
  end

  // Record accepted words and tokens between edges.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (out_valid && out_ready) begin
      got.push_back(out);
      got_cyc.push_back(cyc);
    end
    if (in_valid && in_ready) acc_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, g, e);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_work();
    work = 1'b1;
    wait_cycles(1);
    work = 1'b0;
  endtask

  task automatic send(input bit b, input int r, input bit l);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_bit = b;
    in_run = r[RW-1:0];
    in_last = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    wait_cycles(1);
    in_valid = 1'b0;
    in_last = 1'b0;
    check("token_accepted", 32'(ok), 32'd1);
  endtask

  function automatic vec_t mk(int n, int b0, int r0, int b1, int r1, int b2, int r2, bit l,
                              int nexp, int w0, int w1, int eby, int ebi, bit ed);
    vec_t v;
    v.n = n;
    v.b[0] = b0[0]; v.b[1] = b1[0]; v.b[2] = b2[0];
    v.r[0] = r0; v.r[1] = r1; v.r[2] = r2;
    v.last = l;
    v.nexp = nexp;
    v.w[0] = w0[7:0]; v.w[1] = w1[7:0];
    v.ebyte = eby; v.ebit = ebi; v.edone = ed;
    return v;
  endfunction

  initial begin
    vecs[0] = mk(3, 1, 3, 0, 2, 1, 3, 0, 1, 'hE7, 0, 1, 0, 0);
    vecs[1] = mk(2, 1, 15, 0, 1, 0, 0, 0, 2, 'hFF, 'hFE, 2, 0, 1);
    vecs[2] = mk(1, 1, 3, 0, 0, 0, 0, 1, 1, 'hE0, 0, 1, 0, 1);
    vecs[3] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    vecs[4] = mk(3, 1, 5, 0, 0, 0, 2, 0, 0, 0, 0, 0, 7, 0);
    vecs[5] = mk(2, 0, 4, 1, 2, 0, 0, 1, 1, 'h0C, 0, 1, 0, 1);
    vecs[6] = mk(2, 1, 15, 1, 5, 0, 0, 0, 2, 'hFF, 'hFF, 2, 0, 1);

    // Reset values, and IDLE does not accept tokens.
    wait_cycles(2);
    check("rst_out", 32'(out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_byteIndx", 32'(byteIndx), 32'd0);
    check("rst_bitIndx", 32'(bitIndx), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    wait_cycles(2);
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Directed vector table.
    for (int v = 0; v < 7; v++) begin
      got.delete();
      pulse_work();
      check("work_in_ready", 32'(in_ready), 32'd1);
      check("work_byteIndx", 32'(byteIndx), 32'd0);
      check("work_bitIndx", 32'(bitIndx), 32'd0);
      for (int i = 0; i < vecs[v].n; i++) begin
        send(vecs[v].b[i], vecs[v].r[i], vecs[v].last && (i == vecs[v].n - 1));
      end
      wait_cycles(20);
      check($sformatf("vec%0d_nwords", v), 32'(got.size()), 32'(vecs[v].nexp));
      for (int w = 0; w < vecs[v].nexp && w < got.size(); w++) begin
        check($sformatf("vec%0d_word%0d", v, w), 32'(got[w]), 32'(vecs[v].w[w]));
      end
      check($sformatf("vec%0d_byteIndx", v), 32'(byteIndx), 32'(vecs[v].ebyte));
      check($sformatf("vec%0d_bitIndx", v), 32'(bitIndx), 32'(vecs[v].ebit));
      check($sformatf("vec%0d_done", v), 32'(done), 32'(vecs[v].edone));
      if (vecs[v].edone) check($sformatf("vec%0d_done_ready", v), 32'(in_ready), 32'd0);
    end

    // Latency: token accepted at t, word visible at t+2.
    pulse_work();
    send(1'b1, 8, 1'b0);
    check("lat_valid_early", 32'(out_valid), 32'd0);
    wait_cycles(1);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_out", 32'(out), 32'hFF);
    check("lat_byteIndx", 32'(byteIndx), 32'd1);
    wait_cycles(2);

    // Back-pressure: second word stalls in the assembly register, then both drain.
    got.delete();
    got_cyc.delete();
    rdy_fix = 1'b0;
    pulse_work();
    send(1'b1, 15, 1'b0);
    send(1'b0, 1, 1'b0);
    wait_cycles(3);
    check("bp_out", 32'(out), 32'hFF);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_bitIndx", 32'(bitIndx), 32'd8);
    wait_cycles(2);
    check("bp_out_hold", 32'(out), 32'hFF);
    check("bp_none_taken", 32'(got.size()), 32'd0);
    rdy_fix = 1'b1;
    wait_cycles(5);
    check("bp_nwords", 32'(got.size()), 32'd2);
    if (got.size() >= 2) begin
      check("bp_word0", 32'(got[0]), 32'hFF);
      check("bp_word1", 32'(got[1]), 32'hFE);
      check("bp_gap", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
    end
    check("bp_done", 32'(done), 32'd1);

    // Asynchronous reset mid-frame with a word pending on out.
    rdy_fix = 1'b0;
    pulse_work();
    send(1'b1, 15, 1'b0);
    wait_cycles(2);
    check("mr_valid_before", 32'(out_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_out", 32'(out), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_in_ready", 32'(in_ready), 32'd0);
    check("mr_bitIndx", 32'(bitIndx), 32'd0);
    check("mr_byteIndx", 32'(byteIndx), 32'd0);
    wait_cycles(1);
    rst = 1'b0;
    rdy_fix = 1'b1;
    acc0 = acc_cnt;
    in_valid = 1'b1;
    in_run = 4'd3;
    wait_cycles(5);
    check("mr_no_accept", 32'(acc_cnt - acc0), 32'd0);
    in_valid = 1'b0;

    // Randomised frames against the bit-queue model.
    for (int f = 0; f < 40; f++) begin
      got.delete();
      q.delete();
      cum = 0;
      lastf = 1'b0;
      pulse_work();
      rnd_mode = 1'b1;
      ntok = $urandom_range(1, 6);
      for (int i = 0; i < ntok; i++) begin
        if (cum >= int'(TW * WW)) break;
        rr = $urandom_range(0, 15);
        bb = 1'($urandom_range(0, 1));
        ll = (i == ntok - 1) && ($urandom_range(0, 1) == 1);
        send(bb, rr, ll);
        for (int j = 0; j < rr; j++) q.push_back(bb);
        cum += rr;
        lastf = ll;
      end
      rnd_mode = 1'b0;
      wait_cycles(30);
      nw = lastf ? (cum + 7) / 8 : cum / 8;
      if (nw > int'(TW)) nw = TW;
      exp_done = lastf || (cum >= int'(TW * WW));
      check($sformatf("rnd%0d_nwords", f), 32'(got.size()), 32'(nw));
      for (int w = 0; w < nw && w < got.size(); w++) begin
        ew = '0;
        for (int j = 0; j < 8; j++) begin
          ew = {ew[6:0], ((w * 8 + j) < q.size()) ? q[w * 8 + j] : 1'b0};
        end
        check($sformatf("rnd%0d_word%0d", f, w), 32'(got[w]), 32'(ew));
      end
      check($sformatf("rnd%0d_byteIndx", f), 32'(byteIndx), 32'(nw));
      check($sformatf("rnd%0d_bitIndx", f), 32'(bitIndx), exp_done ? 32'd0 : 32'(cum % 8));
      check($sformatf("rnd%0d_done", f), 32'(done), 32'(exp_done));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rle_decompressor.md
# rle_decompressor

Parametrised, clocked run-length decompressor for the DCNN IO path. It consumes a stream of {bit value, run length} tokens and expands them into packed WORD_W-bit output words, MSB first. Tokens arrive and words leave over valid/ready handshakes. It tracks word index and bit position and raises `done` after TOTAL_WORDS words. It succeeds the fixed two-token, 8-bit combinational decompressor, adding width, run-length and frame-size parameters, back-pressure, and multi-cycle expansion of long runs.

## Interface
- WORD_W, 8, output word width in bits (≥2)
- RUN_W, 2, width of the run-length field
- IDX_W, 32, width of `byteIndx`
- TOTAL_WORDS, 1024, words per frame; `done` asserts after the last one
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- work  in  1  start pulse; clears counters and begins a frame
- in_valid  in  1  token valid
- in_ready  out  1  token accepted when in_valid && in_ready
- in_bit  in  1  bit value of the run
- in_run  in  RUN_W  run length in bits; 0 is a null token
- in_last  in  1  last token of frame; flushes a partial word
- out  out  WORD_W  packed output word
- out_valid  out  1  out holds a word
- out_ready  in  1  consumer accepts word
- byteIndx  out  IDX_W  number of words emitted this frame
- bitIndx  out  $clog2(WORD_W+1)  bits filled in the assembly word (0..WORD_W)
- done  out  1  frame complete

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: in_ready=0. A `work` pulse clears byteIndx, bitIndx, the pending run, and the assembly word, then moves to RUN.
- `work` in any non-IDLE state restarts the frame the same way. A word already in `out` stays valid until it is accepted.
- RUN, token acceptance:
  - in_ready=1 only when no run is pending and the assembly word is not full.
  - An accepted token loads run_left=in_run and bit_val=in_bit.
  - A null token (in_run=0) is consumed with no effect unless in_last=1.
- RUN, expansion: each cycle with run_left>0 and assembly not full, append k = min(run_left, WORD_W−bitIndx) copies of bit_val at positions WORD_W−1−bitIndx downward. Then bitIndx+=k and run_left−=k.
- Word transfer: when bitIndx==WORD_W, the assembly word moves to the `out` register if `out` is empty or is being accepted that cycle. On transfer, bitIndx=0 and byteIndx+=1. Otherwise expansion stalls.
- in_last: when the last token's run is fully expanded and bitIndx>0, go to FLUSH. FLUSH zero-pads the low bits and transfers the word as above.
- in_last with bitIndx==0: go straight to DONE once `out` drains.
- When byteIndx reaches TOTAL_WORDS on a transfer, go to DONE. Any remaining run_left is discarded and in_ready=0.
- DONE: done=1, in_ready=0. Stays in DONE until `work` or `rst`.
- Arithmetic: byteIndx wraps modulo 2^IDX_W (only reachable if TOTAL_WORDS ≥ 2^IDX_W). All counters are unsigned.

## Timing
- Reset values: out=0, out_valid=0, in_ready=0, byteIndx=0, bitIndx=0, done=0, state=IDLE.
- in_ready is registered-state derived and asserts the cycle after the `work` pulse.
- A token accepted at cycle t contributes its first bits at t+1. A word completed at t+1 shows out_valid=1 at t+2 when `out` is free.
- A run of R bits starting at bitIndx b needs ceil((b+R)/WORD_W) expansion cycles when output is never stalled.
- out and out_valid hold stable while out_valid && !out_ready.
- Simultaneous out_ready and a word completing: accept the old word and load the new one in the same cycle, with no bubble.
- rst mid-frame: all outputs return to their reset values immediately (asynchronous). A partial word is lost.

## Structure
- Package `rle_pkg`: state enum (IDLE, RUN, FLUSH, DONE) and a `min` function for the k computation.
- Sub-module `bit_packer`: assembly register plus k-bit MSB-first insert and zero-pad. Its inputs are bit_val, k, and bitIndx; it outputs the word. Output register and FSM stay in the top module.

## Test plan
- WORD_W=8, RUN_W=2. Reset, `work`, then tokens (1,3),(0,2),(1,3) with out_ready=1 → out=8'b1110_0111, out_valid for one cycle, byteIndx=1, bitIndx=0.
- WORD_W=8, RUN_W=4. Tokens (1,15),(0,1) → out=8'hFF then 8'hFE, byteIndx=2. Two expansion cycles for the first token.
- Back-pressure: hold out_ready=0 while two words complete → the first word stays on `out`, in_ready drops, bitIndx=8. Release out_ready → both words emitted in order, one cycle apart.
- in_last on token (1,3) at bitIndx=0 → FLUSH, out=8'b1110_0000, then DONE with done=1 and in_ready=0. A null token with in_last at bitIndx=0 → DONE, no extra word.
- TOTAL_WORDS=2 with 20 bits supplied → exactly 2 words, the extra 4 bits are discarded, done=1, and a later `work` clears byteIndx to 0.
- Assert `rst` mid-run with out_valid=1 → out_valid=0, out=0, done=0, state IDLE in the same cycle, and no token is accepted until `work`.
